regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Shares the register file's single write port between the in-order pipeline writeback (WB) and a long-latency multi-cycle unit (MC: mul/div, late loads). MC results are queued in a small FIFO and drained into free write slots. WB gets priority, and an anti-starvation timer guarantees MC progress. A per-register pending scoreboard lets decode detect hazards against outstanding MC writes.

Parameters:
FIFO_DEPTH, 4, MC result queue entries (power of 2, >=2)
MAX_WAIT, 4, cycles a valid FIFO head may lose arbitration before it is forced onto the port (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
wb_valid  in  1  WB write request
wb_rd  in  5  WB destination register
wb_data  in  32  WB data
wb_ready  out  1  WB consumed this cycle; pipeline holds WB when wb_valid & !wb_ready
mc_valid  in  1  MC result valid
mc_rd  in  5  MC destination register
mc_data  in  32  MC result
mc_ready  out  1  FIFO can accept an MC result
iss_valid  in  1  MC operation issued this cycle
iss_rd  in  5  destination of the issued MC operation
q_rs1, q_rs2, q_rd  in  5 each  decode hazard queries
rs1_busy, rs2_busy, rd_busy  out  1 each  queried register has an outstanding MC write
rf_we  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  32  register file write data

Behaviour:
- Reset (rst=0, async): FIFO pointers/count=0, wait counter=0, all pending bits=0. Hence rf_we=0, mc_ready=1, wb_ready=1, all *_busy=0.
- FIFO: push when mc_valid & mc_ready. mc_ready = (count != FIFO_DEPTH). No pass-through when full. MC data is never written the same cycle it arrives; minimum MC latency to the port is 1 cycle.
- Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave count unchanged (legal at any count below full; at full only pop happens).
- force = head_valid & (wait_cnt >= MAX_WAIT).
- Grant is combinational, same cycle:
  - force: port = FIFO head, pop, wb_ready=0.
  - else if wb_valid: port = WB, wb_ready=1.
  - else if head_valid: port = FIFO head, pop.
  - else rf_we=0.
- wb_ready=1 whenever force=0, including when wb_valid=0.
- rf_we = granted source valid & (addr != 0). Writes to x0 are dropped but still consume the grant/pop.
- wait_cnt: cleared on reset, on pop, and whenever the FIFO is empty. Otherwise increments by 1 per cycle the head is valid and not popped, and saturates at MAX_WAIT.
- Scoreboard, pending[31:1]:
  - iss_valid & iss_rd!=0 sets pending[iss_rd].
  - A pop with head rd!=0 clears pending[head rd].
  - Same register set and cleared in one cycle: set wins, because a newer op is outstanding.
  - pending[0] is constant 0.
- Scoreboard queries are combinational from the registered state. A register set this cycle reads busy from the next cycle.
- x_busy = pending[q_x]. Decode must stall on any busy rs or rd. WAW and RAW ordering against MC writes are the pipeline's responsibility via these outputs.
- All state updates on posedge clk only; async reset overrides. Reset mid-drain discards FIFO contents and pending bits.

Test Plan:
- Reset mid-stream: with 3 entries queued and x5 pending, pull rst=0 -> immediately rf_we=0, mc_ready=1, rs1_busy(q_rs1=5)=0; after release FIFO empty.
- WB only: wb_valid=1, wb_rd=3, wb_data=0xDEADBEEF, FIFO empty -> same cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF, wb_ready=1; wb_rd=0 -> rf_we=0, wb_ready=1.
- MC drain: issue rd=7, then push mc_rd=7, mc_data=0x12345678 with wb idle -> rd_busy(q_rd=7)=1 from the cycle after issue; the write occurs the cycle after the push; pending[7] clears the following cycle.
- Starvation: FIFO head valid while wb_valid=1 continuously for MAX_WAIT=4 cycles -> 5th cycle forced: rf_waddr=head rd, wb_ready=0; next cycle WB granted again with wait_cnt=0.
- Full FIFO: 4 pushes with wb busy every cycle -> mc_ready=0 after the 4th; a 5th mc_valid is not accepted; after one pop mc_ready=1; simultaneous push+pop at count=2 keeps count=2.
- Set/clear collision: pop head rd=9 in the same cycle as iss_rd=9 -> pending[9] remains 1; a later pop of rd=9 clears it.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Single register-file write port shared by pipeline writeback and a queued multi-cycle unit.
// WB wins by default; a wait timer forces the MC queue head through, and a scoreboard tracks outstanding MC writes.
module regfile_wr_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        mc_valid,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    input  logic [4:0]  q_rd,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_busy,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    logic [4:0]    fifoRd_q   [FIFO_DEPTH];
    logic [31:0]   fifoData_q [FIFO_DEPTH];
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] waitCnt_q, waitCnt_d;
    logic [31:1]   pending_q, pending_d;

    logic          headValid;
    logic          forceMc;
    logic          push;
    logic          pop;
    logic [4:0]    headRd;
    logic [31:0]   headData;
    logic          grantValid;
    logic [4:0]    grantAddr;
    logic [31:0]   grantData;
    logic [31:0]   pendingAll;

    assign headRd    = fifoRd_q[rdPtr_q];
    assign headData  = fifoData_q[rdPtr_q];
    assign headValid = (count_q != '0);
    assign forceMc   = headValid && (waitCnt_q >= WAIT_MAX);
    assign mc_ready  = (count_q != FULL_CNT);
    assign push      = mc_valid && mc_ready;

    // A starved head takes the port outright; otherwise the queue only fills idle WB slots.
    always_comb begin
        grantValid = 1'b0;
        grantAddr  = 5'd0;
        grantData  = 32'd0;
        pop        = 1'b0;
        wb_ready   = 1'b1;
        if (forceMc) begin
            grantValid = 1'b1;
            grantAddr  = headRd;
            grantData  = headData;
            pop        = 1'b1;
            wb_ready   = 1'b0;
        end else if (wb_valid) begin
            grantValid = 1'b1;
            grantAddr  = wb_rd;
            grantData  = wb_data;
        end else if (headValid) begin
            grantValid = 1'b1;
            grantAddr  = headRd;
            grantData  = headData;
            pop        = 1'b1;
        end
    end

    assign rf_we    = grantValid && (grantAddr != 5'd0);
    assign rf_waddr = grantAddr;
    assign rf_wdata = grantData;

    always_comb begin
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d = count_q + CW'(push) - CW'(pop);

        waitCnt_d = waitCnt_q;
        if (pop || !headValid) begin
            waitCnt_d = '0;
        end else if (waitCnt_q < WAIT_MAX) begin
            waitCnt_d = waitCnt_q + 1'b1;
        end

        // Set is applied after clear so a freshly issued op to the same register stays outstanding.
        pending_d = pending_q;
        if (pop && (headRd != 5'd0)) begin
            pending_d[headRd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            pending_d[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            waitCnt_q <= '0;
            pending_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            waitCnt_q <= waitCnt_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoRd_q[wrPtr_q]   <= mc_rd;
            fifoData_q[wrPtr_q] <= mc_data;
        end
    end

    assign pendingAll = {pending_q, 1'b0};
    assign rs1_busy   = pendingAll[q_rs1];
    assign rs2_busy   = pendingAll[q_rs2];
    assign rd_busy    = pendingAll[q_rd];

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a queue-based reference model.
// Inputs change at negedge; outputs are compared 1ns later and the model advances at posedge.
module tb_regfile_wr_arbiter;

    localparam int DEPTH = 4;
    localparam int MAXW  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        wb_ready;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_rd = '0;
    logic [31:0] mc_data = '0;
    logic        mc_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic [4:0]  q_rs1 = '0;
    logic [4:0]  q_rs2 = '0;
    logic [4:0]  q_rd = '0;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    regfile_wr_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t mq[$];
    int     mWait;
    bit     mPend[32];
    int     testCount = 0;
    int     failCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mWait = 0;
        for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
    endtask

    task automatic setIdle();
        wb_valid  = 1'b0; wb_rd = '0; wb_data = '0;
        mc_valid  = 1'b0; mc_rd = '0; mc_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
    endtask

    // Called just after a negedge with inputs already driven: checks, clocks, advances the model.
    task automatic applyStimulus();
        bit          head, frc, pop, srcV, wbr, push;
        logic [4:0]  a;
        logic [31:0] d;
        entry_t      e;
        #1;
        head = (mq.size() > 0);
        frc  = head && (mWait >= MAXW);
        pop = 0; srcV = 0; wbr = 1; a = '0; d = '0;
        if (frc) begin
            pop = 1; srcV = 1; wbr = 0; a = mq[0].rd; d = mq[0].data;
        end else if (wb_valid) begin
            srcV = 1; a = wb_rd; d = wb_data;
        end else if (head) begin
            pop = 1; srcV = 1; a = mq[0].rd; d = mq[0].data;
        end
        checkOutput("rf_we", {31'd0, rf_we}, {31'd0, srcV && (a != 5'd0)});
        if (srcV && (a != 5'd0)) begin
            checkOutput("rf_waddr", {27'd0, rf_waddr}, {27'd0, a});
            checkOutput("rf_wdata", rf_wdata, d);
        end
        checkOutput("wb_ready", {31'd0, wb_ready}, {31'd0, wbr});
        checkOutput("mc_ready", {31'd0, mc_ready}, {31'd0, mq.size() < DEPTH});
        checkOutput("rs1_busy", {31'd0, rs1_busy}, {31'd0, mPend[q_rs1]});
        checkOutput("rs2_busy", {31'd0, rs2_busy}, {31'd0, mPend[q_rs2]});
        checkOutput("rd_busy", {31'd0, rd_busy}, {31'd0, mPend[q_rd]});
        push = mc_valid && (mq.size() < DEPTH);
        @(posedge clk);
        if (pop) begin
            if (a != 5'd0) mPend[a] = 1'b0;
            void'(mq.pop_front());
        end
        if (pop || !head) mWait = 0;
        else if (mWait < MAXW) mWait++;
        if (iss_valid && (iss_rd != 5'd0)) mPend[iss_rd] = 1'b1;
        if (push) begin
            e.rd = mc_rd; e.data = mc_data;
            mq.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        modelReset();
        setIdle();
        q_rs1 = 5'd5; q_rs2 = 5'd7; q_rd = 5'd9;
        @(negedge clk);
        #1;
        checkOutput("reset_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("reset_mc_ready", {31'd0, mc_ready}, 32'd1);
        checkOutput("reset_wb_ready", {31'd0, wb_ready}, 32'd1);
        checkOutput("reset_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // WB alone owns the port; a write to x0 is suppressed.
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        #1;
        checkOutput("wb_only_we", {31'd0, rf_we}, 32'd1);
        checkOutput("wb_only_data", rf_wdata, 32'hDEADBEEF);
        applyStimulus();
        wb_rd = 5'd0;
        applyStimulus();

        // Issue x7, push its result, watch busy rise then clear after the drain write.
        setIdle();
        q_rd = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        applyStimulus();
        iss_valid = 1'b0;
        mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h12345678;
        #1;
        checkOutput("drain_busy_after_issue", {31'd0, rd_busy}, 32'd1);
        applyStimulus();
        mc_valid = 1'b0;
        #1;
        checkOutput("drain_waddr", {27'd0, rf_waddr}, 32'd7);
        applyStimulus();
        #1;
        checkOutput("drain_busy_cleared", {31'd0, rd_busy}, 32'd0);

        // Starvation: continuous WB, head forced after MAX_WAIT lost cycles.
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'hA5A5A5A5;
        mc_valid = 1'b1; mc_rd = 5'd11; mc_data = 32'h0000BEEF;
        applyStimulus();
        mc_valid = 1'b0;
        repeat (MAXW) applyStimulus();
        #1;
        checkOutput("starve_wb_ready", {31'd0, wb_ready}, 32'd0);
        checkOutput("starve_waddr", {27'd0, rf_waddr}, 32'd11);
        applyStimulus();
        applyStimulus();

        // Fill the queue while WB is busy; a fifth result must be refused.
        for (int i = 1; i <= 5; i++) begin
            mc_valid = 1'b1; mc_rd = 5'(i); mc_data = 32'(i * 16);
            if (i == 5) begin
                #1;
                checkOutput("full_mc_ready", {31'd0, mc_ready}, 32'd0);
            end
            applyStimulus();
        end
        mc_valid = 1'b0; wb_valid = 1'b0;
        repeat (6) applyStimulus();

        // Set/clear collision on x9.
        setIdle();
        q_rs1 = 5'd9;
        iss_valid = 1'b1; iss_rd = 5'd9;
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h99;
        applyStimulus();
        mc_valid = 1'b0;
        applyStimulus();
        iss_valid = 1'b0;
        #1;
        checkOutput("collision_busy_kept", {31'd0, rs1_busy}, 32'd1);
        mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h999;
        applyStimulus();
        mc_valid = 1'b0;
        applyStimulus();
        applyStimulus();

        // Reset with three entries queued and x5 pending.
        setIdle();
        q_rs1 = 5'd5;
        wb_valid = 1'b1; wb_rd = 5'd1;
        iss_valid = 1'b1; iss_rd = 5'd5;
        for (int i = 0; i < 3; i++) begin
            mc_valid = 1'b1; mc_rd = 5'(5 + i); mc_data = 32'(100 + i);
            applyStimulus();
            iss_valid = 1'b0;
        end
        setIdle();
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("midreset_rf_we", {31'd0, rf_we}, 32'd0);
        checkOutput("midreset_mc_ready", {31'd0, mc_ready}, 32'd1);
        checkOutput("midreset_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            wb_valid  = ($urandom_range(0, 99) < 55);
            wb_rd     = 5'($urandom_range(0, 31));
            wb_data   = $urandom;
            mc_valid  = ($urandom_range(0, 99) < 45);
            mc_rd     = 5'($urandom_range(0, 12));
            mc_data   = $urandom;
            iss_valid = ($urandom_range(0, 99) < 40);
            iss_rd    = 5'($urandom_range(0, 12));
            q_rs1     = 5'($urandom_range(0, 12));
            q_rs2     = 5'($urandom_range(0, 12));
            q_rd      = 5'($urandom_range(0, 12));
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
